// File: rtl/spart_pkg.sv
// Shared SPART definitions: byte width, FIFO fill-width helper and the
// ioaddr encodings used by the CPU-side driver.
package spart_pkg;

  localparam int unsigned SPART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IoaddrTxRx   = 2'b00,
    IoaddrStatus = 2'b01,
    IoaddrDbLow  = 2'b10,
    IoaddrDbHigh = 2'b11
  } spart_ioaddr_e;

  // Occupancy runs 0..depth inclusive, so one extra bit over the pointer width.
  function automatic int unsigned fill_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spart_word_rx_if.sv
// Receive/CPU-side signal bundle of spart_word_rx. master = SPART/CPU side,
// slave = spart_word_rx.
interface spart_word_rx_if #(
  parameter int unsigned BYTES_PER_WORD = 1,
  parameter int unsigned FIFO_DEPTH     = 4
);
  import spart_pkg::*;

  logic                                    rx_valid;
  logic [SPART_BYTE_W-1:0]                 rx_data;
  logic [SPART_BYTE_W*BYTES_PER_WORD-1:0]  word_data;
  logic                                    word_valid;
  logic                                    word_ready;
  logic [fill_width(FIFO_DEPTH)-1:0]       fill;
  logic                                    overflow;
  logic                                    ovf_clr;
  logic                                    frame_err;
  logic                                    tbr;
  logic                                    tx_req;
  logic [SPART_BYTE_W-1:0]                 tx_data;

  modport master (
    output rx_valid, rx_data, word_ready, ovf_clr, tbr,
    input  word_data, word_valid, fill, overflow, frame_err, tx_req, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, word_ready, ovf_clr, tbr,
    output word_data, word_valid, fill, overflow, frame_err, tx_req, tx_data
  );

endinterface

// File: rtl/spart_word_fifo.sv
// Show-ahead synchronous word FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped (drop_o).
module spart_word_fifo import spart_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [fill_width(DEPTH)-1:0]  fill_o,
  output logic                          drop_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned FillW = fill_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FillW-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == FillW'(DEPTH));
    pop_ok  = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop_ok);
    drop_o  = push_i & ~push_ok;
    wptr_d  = push_ok ? wptr_q + AddrW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AddrW'(1) : rptr_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + FillW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - FillW'(1);
    end
    // Stale entries are masked so the head reads zero when empty.
    data_o = empty_o ? '0 : mem_q[rptr_q];
    fill_o = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/spart_word_rx.sv
// Assembles SPART receive bytes into words with inter-byte timeout and buffers
// them in spart_word_fifo. Byte echo to the transmitter is built only when
// SPART_ECHO_EN is defined.
module spart_word_rx import spart_pkg::*; #(
  parameter int unsigned BYTES_PER_WORD = 1,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYC    = 50000
) (
  input logic             clk,
  input logic             rst,
  spart_word_rx_if.slave  bus
);

  localparam int unsigned BcntW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned TmrW  = $clog2(TIMEOUT_CYC);
  localparam logic [BcntW-1:0] LastLane = BcntW'(BYTES_PER_WORD - 1);
  localparam logic [TmrW-1:0]  TmrLast  = TmrW'(TIMEOUT_CYC - 1);

  logic [BYTES_PER_WORD-1:0][SPART_BYTE_W-1:0] word_q, word_d, asm_word;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic             frame_err_q, frame_err_d;
  logic             ovf_q, ovf_d;
  logic             push, drop, expire, fifo_empty, unused_full;

  always_comb begin
    asm_word = word_q;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (bcnt_q == BcntW'(i)) asm_word[i] = bus.rx_data;
    end
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    tmr_d       = tmr_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    expire      = (bcnt_q != '0) && (tmr_q == TmrLast);
    // A byte arriving on the expiry cycle wins: it is kept and the timer restarts.
    if (bus.rx_valid) begin
      tmr_d = '0;
      if (bcnt_q == LastLane) begin
        push   = 1'b1;
        bcnt_d = '0;
        word_d = '0;
      end else begin
        bcnt_d = bcnt_q + BcntW'(1);
        word_d = asm_word;
      end
    end else if (expire) begin
      bcnt_d      = '0;
      word_d      = '0;
      tmr_d       = '0;
      frame_err_d = 1'b1;
    end else if (bcnt_q != '0) begin
      tmr_d = tmr_q + TmrW'(1);
    end
    ovf_d = (ovf_q & ~bus.ovf_clr) | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q      <= '0;
      bcnt_q      <= '0;
      tmr_q       <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      tmr_q       <= tmr_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  spart_word_fifo #(
    .WIDTH (SPART_BYTE_W * BYTES_PER_WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (asm_word),
    .pop_i   (bus.word_ready),
    .data_o  (bus.word_data),
    .full_o  (unused_full),
    .empty_o (fifo_empty),
    .fill_o  (bus.fill),
    .drop_o  (drop)
  );

  assign bus.word_valid = ~fifo_empty;
  assign bus.overflow   = ovf_q;
  assign bus.frame_err  = frame_err_q;

`ifdef SPART_ECHO_EN
  logic                    echo_full_q, echo_full_d, echo_drain;
  logic [SPART_BYTE_W-1:0] echo_data_q, echo_data_d;

  always_comb begin
    echo_drain  = echo_full_q & bus.tbr;
    echo_full_d = echo_full_q & ~echo_drain;
    echo_data_d = echo_data_q;
    // A draining register can take the new byte in the same cycle.
    if (bus.rx_valid && (!echo_full_q || echo_drain)) begin
      echo_full_d = 1'b1;
      echo_data_d = bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_full_q <= 1'b0;
      echo_data_q <= '0;
    end else begin
      echo_full_q <= echo_full_d;
      echo_data_q <= echo_data_d;
    end
  end

  assign bus.tx_req  = echo_drain;
  assign bus.tx_data = echo_data_q;
`else
  logic unused_tbr;
  assign unused_tbr  = bus.tbr;
  assign bus.tx_req  = 1'b0;
  assign bus.tx_data = '0;
`endif

endmodule

// File: tb/tb_spart_word_rx.sv
// Directed bench for spart_word_rx (4-byte words, 4-deep FIFO, 10-cycle timeout).
module tb_spart_word_rx;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spart_word_rx_if #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4)) bus ();

  spart_word_rx #(
    .BYTES_PER_WORD (4),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYC    (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  logic [31:0] words [5];

  initial begin
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.word_ready = 1'b0;
    bus.ovf_clr    = 1'b0;
    bus.tbr        = 1'b0;
    #12;
    check("rst_word_valid", 64'(bus.word_valid), 64'd0);
    check("rst_fill", 64'(bus.fill), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_frame_err", 64'(bus.frame_err), 64'd0);
    check("rst_tx_req", 64'(bus.tx_req), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_word_data", 64'(bus.word_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Basic assembly, little-endian lanes.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("asm_not_yet_valid", 64'(bus.word_valid), 64'd0);
    send_byte(8'h44);
    check("asm_valid", 64'(bus.word_valid), 64'd1);
    check("asm_data", 64'(bus.word_data), 64'h44332211);
    check("asm_fill", 64'(bus.fill), 64'd1);
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    check("pop_empty_valid", 64'(bus.word_valid), 64'd0);
    check("pop_empty_fill", 64'(bus.fill), 64'd0);

    // Overflow: five words into a four-deep FIFO.
    for (int k = 0; k < 5; k++) words[k] = 32'h0101_0101 * (k + 1);
    for (int k = 0; k < 4; k++) send_word(words[k]);
    check("full_fill", 64'(bus.fill), 64'd4);
    check("full_no_ovf", 64'(bus.overflow), 64'd0);
    send_word(words[4]);
    check("ovf_fill", 64'(bus.fill), 64'd4);
    check("ovf_set", 64'(bus.overflow), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovf_order%0d", k), 64'(bus.word_data), 64'(words[k]));
      bus.word_ready = 1'b1;
      step();
    end
    bus.word_ready = 1'b0;
    check("drained_valid", 64'(bus.word_valid), 64'd0);
    check("ovf_sticky", 64'(bus.overflow), 64'd1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", 64'(bus.overflow), 64'd0);

    // Full FIFO: final byte coincides with a pop, so the push is accepted.
    for (int k = 0; k < 4; k++) send_word(words[k]);
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    bus.rx_valid   = 1'b1;
    bus.rx_data    = 8'hB4;
    bus.word_ready = 1'b1;
    step();
    bus.rx_valid   = 1'b0;
    bus.word_ready = 1'b0;
    check("popfull_fill", 64'(bus.fill), 64'd4);
    check("popfull_no_ovf", 64'(bus.overflow), 64'd0);
    words[0] = words[1];
    words[1] = words[2];
    words[2] = words[3];
    words[3] = 32'hB4B3B2B1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("popfull_order%0d", k), 64'(bus.word_data), 64'(words[k]));
      bus.word_ready = 1'b1;
      step();
    end
    bus.word_ready = 1'b0;
    check("popfull_drained", 64'(bus.fill), 64'd0);

    // Pop on empty FIFO is ignored.
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    check("pop_empty_ignored", 64'(bus.fill), 64'd0);

    // Timeout: two bytes then silence.
    send_byte(8'hE1);
    send_byte(8'hE2);
    for (int i = 0; i < 9; i++) step();
    check("tmo_before", 64'(bus.frame_err), 64'd0);
    step();
    check("tmo_pulse", 64'(bus.frame_err), 64'd1);
    step();
    check("tmo_pulse_end", 64'(bus.frame_err), 64'd0);
    send_word(32'hA4A3A2A1);
    check("tmo_next_word", 64'(bus.word_data), 64'hA4A3A2A1);
    check("tmo_next_fill", 64'(bus.fill), 64'd1);
    check("tmo_no_extra_word", 64'(bus.frame_err), 64'd0);

    // Asynchronous reset mid-word with two words queued.
    send_word(32'h0BADF00D);
    send_byte(8'h77);
    send_byte(8'h88);
    check("prerst_fill", 64'(bus.fill), 64'd2);
    rst = 1'b0;
    #1;
    check("arst_word_valid", 64'(bus.word_valid), 64'd0);
    check("arst_fill", 64'(bus.fill), 64'd0);
    check("arst_word_data", 64'(bus.word_data), 64'd0);
    check("arst_overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    send_word(32'hDEADBEEF);
    check("postrst_data", 64'(bus.word_data), 64'hDEADBEEF);
    check("postrst_fill", 64'(bus.fill), 64'd1);
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;

`ifdef SPART_ECHO_EN
    bus.tbr = 1'b1;
    step();
    step();
    send_byte(8'h5A);
    check("echo_req", 64'(bus.tx_req), 64'd1);
    check("echo_data", 64'(bus.tx_data), 64'h5A);
    step();
    check("echo_req_end", 64'(bus.tx_req), 64'd0);
    bus.tbr = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    check("echo_hold", 64'(bus.tx_req), 64'd0);
    bus.tbr = 1'b1;
    #1;
    check("echo_late_req", 64'(bus.tx_req), 64'd1);
    check("echo_late_data", 64'(bus.tx_data), 64'h01);
    step();
    check("echo_second_dropped", 64'(bus.tx_req), 64'd0);
`else
    bus.tbr = 1'b1;
    send_byte(8'h5A);
    check("noecho_req", 64'(bus.tx_req), 64'd0);
    check("noecho_data", 64'(bus.tx_data), 64'd0);
    step();
    check("noecho_req_late", 64'(bus.tx_req), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
